// File: rtl/ddr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr_pkg
// Description : Shared types and constants for the DDR write burst engine.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_AW        = 3'd2,
        ST_W         = 3'd3,
        ST_B         = 3'd4,
        ST_DONE      = 3'd5,
        ST_COOL      = 3'd6
    } state_t;

    // Bytes per beat for the default 256-bit data path.
    localparam int BYTES = 32;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    function automatic int bytes_per_beat(input int data_width);
        return data_width / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_wr_burst.sv
`default_nettype none
// ============================================================================
// Module      : ddr_wr_burst
// Description : Drains a pixel FIFO into DDR as AXI4 INCR write bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_wr_burst
    import ddr_pkg::*;
#(
    parameter int ADDR_WIDTH     = 30,
    parameter int WR_NUM_WIDTH   = 16,
    parameter int DATA_WIDTH     = 256,
    parameter int BURST_LEN      = 16,
    parameter int FIFO_CNT_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      wr_addr_valid,
    input  logic [ADDR_WIDTH-1:0]     wr_ddr_addr,
    input  logic [WR_NUM_WIDTH-1:0]   wr_ddr_num,
    output logic                      wr_ddr_done,

    input  logic [FIFO_CNT_WIDTH-1:0] fifo_rd_cnt,
    input  logic [DATA_WIDTH-1:0]     fifo_dout,
    output logic                      fifo_rd_en,

    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    output logic [7:0]                m_awlen,
    output logic                      m_awvalid,
    input  logic                      m_awready,

    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                      m_wlast,
    output logic                      m_wvalid,
    input  logic                      m_wready,

    input  logic                      m_bvalid,
    output logic                      m_bready,

    output logic                      busy
);

    localparam int LEN_W      = $clog2(BURST_LEN + 1);
    localparam int BEAT_BYTES = bytes_per_beat(DATA_WIDTH);

    state_t                    state;
    state_t                    state_nx;

    logic [ADDR_WIDTH-1:0]     addr;
    logic [WR_NUM_WIDTH-1:0]   rem;
    logic [LEN_W-1:0]          beat;

    logic [LEN_W-1:0]          len;
    logic [WR_NUM_WIDTH-1:0]   rem_after;
    logic [ADDR_WIDTH-1:0]     addr_step;
    logic                      data_ready;
    logic                      w_hs;
    logic                      last_beat;

    // Current burst length; rem is frozen from WAIT_DATA through B, so len is too.
    always_comb begin
        len = rem[LEN_W-1:0];
        if (rem >= WR_NUM_WIDTH'(BURST_LEN)) begin
            len = LEN_W'(BURST_LEN);
        end
    end

    assign rem_after  = rem - WR_NUM_WIDTH'(len);
    assign addr_step  = ADDR_WIDTH'(len) * ADDR_WIDTH'(BEAT_BYTES);
    assign data_ready = 32'(fifo_rd_cnt) >= 32'(len);
    assign w_hs       = (state == ST_W) && m_wready;
    assign last_beat  = (beat == len - LEN_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        m_awvalid   = 1'b0;
        m_awaddr    = addr;
        m_awlen     = 8'd0;
        m_wvalid    = 1'b0;
        m_wdata     = '0;
        m_wlast     = 1'b0;
        m_bready    = 1'b0;
        wr_ddr_done = 1'b0;
        busy        = 1'b1;

        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (wr_addr_valid) begin
                    state_nx = (wr_ddr_num == '0) ? ST_DONE : ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (data_ready) begin
                    state_nx = ST_AW;
                end
            end
            ST_AW: begin
                m_awvalid = 1'b1;
                m_awlen   = 8'(len - LEN_W'(1));
                if (m_awready) begin
                    state_nx = ST_W;
                end
            end
            ST_W: begin
                m_wvalid = 1'b1;
                m_wdata  = fifo_dout;
                m_wlast  = last_beat;
                if (m_wready && last_beat) begin
                    state_nx = ST_B;
                end
            end
            ST_B: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    state_nx = (rem_after != '0) ? ST_WAIT_DATA : ST_DONE;
                end
            end
            ST_DONE: begin
                wr_ddr_done = 1'b1;
                state_nx    = ST_COOL;
            end
            ST_COOL: begin
                state_nx = ST_IDLE;
            end
            default: begin
                busy     = 1'b0;
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign fifo_rd_en = m_wvalid & m_wready;
    assign m_wstrb    = '1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr <= '0;
            rem  <= '0;
            beat <= '0;
        end else begin
            if (state == ST_IDLE && wr_addr_valid) begin
                addr <= wr_ddr_addr;
                rem  <= wr_ddr_num;
            end
            if (w_hs) begin
                beat <= last_beat ? '0 : beat + LEN_W'(1);
            end
            // Address wraps modulo 2^ADDR_WIDTH without any flag.
            if (state == ST_B && m_bvalid) begin
                rem  <= rem_after;
                addr <= addr + addr_step;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr_wr_burst.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_wr_burst
// Description : Directed bench for ddr_wr_burst with an AXI slave responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_wr_burst;

    localparam int ADDR_WIDTH     = 30;
    localparam int WR_NUM_WIDTH   = 16;
    localparam int DATA_WIDTH     = 256;
    localparam int BURST_LEN      = 16;
    localparam int FIFO_CNT_WIDTH = 10;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      wr_addr_valid = 1'b0;
    logic [ADDR_WIDTH-1:0]     wr_ddr_addr = '0;
    logic [WR_NUM_WIDTH-1:0]   wr_ddr_num = '0;
    logic                      wr_ddr_done;
    logic [FIFO_CNT_WIDTH-1:0] fifo_rd_cnt = '0;
    logic [DATA_WIDTH-1:0]     fifo_dout;
    logic                      fifo_rd_en;
    logic [ADDR_WIDTH-1:0]     m_awaddr;
    logic [7:0]                m_awlen;
    logic                      m_awvalid;
    logic                      m_awready = 1'b0;
    logic [DATA_WIDTH-1:0]     m_wdata;
    logic [DATA_WIDTH/8-1:0]   m_wstrb;
    logic                      m_wlast;
    logic                      m_wvalid;
    logic                      m_wready = 1'b0;
    logic                      m_bvalid = 1'b0;
    logic                      m_bready;
    logic                      busy;

    always #5 clk = ~clk;

    ddr_wr_burst #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .WR_NUM_WIDTH  (WR_NUM_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .BURST_LEN     (BURST_LEN),
        .FIFO_CNT_WIDTH(FIFO_CNT_WIDTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_addr_valid(wr_addr_valid),
        .wr_ddr_addr  (wr_ddr_addr),
        .wr_ddr_num   (wr_ddr_num),
        .wr_ddr_done  (wr_ddr_done),
        .fifo_rd_cnt  (fifo_rd_cnt),
        .fifo_dout    (fifo_dout),
        .fifo_rd_en   (fifo_rd_en),
        .m_awaddr     (m_awaddr),
        .m_awlen      (m_awlen),
        .m_awvalid    (m_awvalid),
        .m_awready    (m_awready),
        .m_wdata      (m_wdata),
        .m_wstrb      (m_wstrb),
        .m_wlast      (m_wlast),
        .m_wvalid     (m_wvalid),
        .m_wready     (m_wready),
        .m_bvalid     (m_bvalid),
        .m_bready     (m_bready),
        .busy         (busy)
    );

    // FIFO head word is a function of how many words have been popped.
    int pop_total = 0;
    assign fifo_dout = {8{32'(pop_total) ^ 32'h5A5A_0000}};

    int tests = 0;
    int fails = 0;

    int aw_delay = 0;
    bit w_toggle = 1'b0;

    int cyc = 0, pops = 0, done_cnt = 0, tb_beat = 0, aw_wait = 0;
    int data_err = 0, rden_err = 0, aw_stab_err = 0, w_stab_err = 0, gap_err = 0, done_dbl = 0;
    int last_b_cyc = 0, done_cyc = 0;
    bit pend_b = 0, in_burst = 0, aw_seen = 0, prev_done = 0;
    bit prev_aw_stall = 0, prev_w_stall = 0, prev_wlast = 0;
    logic [ADDR_WIDTH-1:0] prev_addr;
    logic [7:0]            prev_len;
    logic [DATA_WIDTH-1:0] prev_wdata;
    logic [31:0] aw_addr_q[$];
    logic [31:0] aw_len_q[$];
    logic [31:0] aw_stall_q[$];
    logic [31:0] wlast_q[$];

    // AXI slave: readies driven after negedge, handshakes sampled 1ns later.
    always begin : mon
        bit hs_aw, hs_w, hs_b;
        @(negedge clk);
        if (!rst_n) begin
            m_awready = 1'b0;
            m_wready  = 1'b0;
            m_bvalid  = 1'b0;
        end else begin
            m_awready = m_awvalid && (aw_wait >= aw_delay);
            m_wready  = w_toggle ? ~m_wready : 1'b1;
            m_bvalid  = pend_b;
        end
        #1;
        cyc++;
        hs_w = 1'b0;
        if (!rst_n) begin
            tb_beat = 0; in_burst = 0; pend_b = 0; aw_wait = 0;
            prev_aw_stall = 0; prev_w_stall = 0; prev_done = 0;
        end else begin
            hs_aw = m_awvalid & m_awready;
            hs_w  = m_wvalid & m_wready;
            hs_b  = m_bvalid & m_bready;
            if (m_awvalid) aw_seen = 1'b1;
            if (fifo_rd_en !== hs_w) rden_err++;
            if (prev_aw_stall && (m_awvalid !== 1'b1 || m_awaddr !== prev_addr || m_awlen !== prev_len))
                aw_stab_err++;
            if (prev_w_stall && (m_wvalid !== 1'b1 || m_wdata !== prev_wdata || m_wlast !== prev_wlast))
                w_stab_err++;
            if (in_burst && m_wvalid !== 1'b1) gap_err++;
            if (wr_ddr_done && prev_done) done_dbl++;
            if (wr_ddr_done) begin done_cnt++; done_cyc = cyc; end
            prev_done = wr_ddr_done;
            if (hs_b) begin pend_b = 1'b0; last_b_cyc = cyc; end
            if (hs_aw) begin
                aw_addr_q.push_back(32'(m_awaddr));
                aw_len_q.push_back(32'(m_awlen));
                aw_stall_q.push_back(32'(aw_wait));
                aw_wait  = 0;
                in_burst = 1'b1;
            end else if (m_awvalid) begin
                aw_wait++;
            end
            if (hs_w) begin
                if (m_wdata !== fifo_dout) data_err++;
                pops++;
                if (m_wlast) begin
                    wlast_q.push_back(32'(tb_beat));
                    tb_beat  = 0;
                    in_burst = 1'b0;
                    pend_b   = 1'b1;
                end else begin
                    tb_beat++;
                end
            end
            prev_aw_stall = m_awvalid & ~m_awready;
            prev_addr     = m_awaddr;
            prev_len      = m_awlen;
            prev_w_stall  = m_wvalid & ~m_wready;
            prev_wdata    = m_wdata;
            prev_wlast    = m_wlast;
        end
        @(posedge clk);
        if (hs_w) pop_total++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, 64'(done_cnt), 64'(target));
    endtask

    task automatic clear_logs();
        aw_addr_q.delete(); aw_len_q.delete(); aw_stall_q.delete(); wlast_q.delete();
        pops = 0; aw_seen = 1'b0;
    endtask

    task automatic start_job(input logic [ADDR_WIDTH-1:0] a, input logic [WR_NUM_WIDTH-1:0] n);
        wr_addr_valid = 1'b1;
        wr_ddr_addr   = a;
        wr_ddr_num    = n;
    endtask

    initial begin : main
        int base;
        bit found;

        // Reset state
        fifo_rd_cnt = 10'd512;
        step(3);
        chk("rst_awvalid", 64'(m_awvalid), 64'd0);
        chk("rst_wvalid", 64'(m_wvalid), 64'd0);
        chk("rst_wlast", 64'(m_wlast), 64'd0);
        chk("rst_bready", 64'(m_bready), 64'd0);
        chk("rst_done", 64'(wr_ddr_done), 64'd0);
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_awaddr", 64'(m_awaddr), 64'd0);
        rst_n = 1'b1;
        step(2);

        // Single job: 32 beats from 0x0, two full bursts
        clear_logs();
        start_job(30'h0, 16'd32);
        step(1);
        chk("t1_wait_busy", 64'(busy), 64'd1);
        chk("t1_wait_awvalid", 64'(m_awvalid), 64'd0);
        wr_addr_valid = 1'b0;
        step(1);
        chk("t1_awvalid_t2", 64'(m_awvalid), 64'd1);
        chk("t1_awaddr_t2", 64'(m_awaddr), 64'h0);
        chk("t1_awlen_t2", 64'(m_awlen), 64'd15);
        wait_done(1, 400, "t1_done");
        chk("t1_aw_count", 64'(aw_addr_q.size()), 64'd2);
        chk("t1_aw0_addr", 64'(aw_addr_q[0]), 64'h0);
        chk("t1_aw1_addr", 64'(aw_addr_q[1]), 64'h200);
        chk("t1_aw0_len", 64'(aw_len_q[0]), 64'd15);
        chk("t1_aw1_len", 64'(aw_len_q[1]), 64'd15);
        chk("t1_pops", 64'(pops), 64'd32);
        chk("t1_done_after_b", 64'(done_cyc - last_b_cyc), 64'd1);
        step(3);
        chk("t1_idle", 64'(busy), 64'd0);
        chk("t1_done_count", 64'(done_cnt), 64'd1);

        // Short tail: 20 beats -> 16 + 4
        clear_logs();
        start_job(30'h1000, 16'd20);
        step(1);
        wr_addr_valid = 1'b0;
        wait_done(2, 400, "t2_done");
        chk("t2_aw_count", 64'(aw_addr_q.size()), 64'd2);
        chk("t2_aw1_addr", 64'(aw_addr_q[1]), 64'h1200);
        chk("t2_aw0_len", 64'(aw_len_q[0]), 64'd15);
        chk("t2_aw1_len", 64'(aw_len_q[1]), 64'd3);
        chk("t2_wlast0", 64'(wlast_q[0]), 64'd15);
        chk("t2_wlast1", 64'(wlast_q[1]), 64'd3);
        chk("t2_pops", 64'(pops), 64'd20);
        step(3);

        // FIFO starvation: 5 words for 50 cycles, then 16
        clear_logs();
        fifo_rd_cnt = 10'd5;
        start_job(30'h2000, 16'd16);
        step(1);
        wr_addr_valid = 1'b0;
        step(50);
        chk("t3_no_aw_starved", 64'(aw_seen), 64'd0);
        chk("t3_busy_starved", 64'(busy), 64'd1);
        fifo_rd_cnt = 10'd16;
        wait_done(3, 400, "t3_done");
        chk("t3_aw_count", 64'(aw_addr_q.size()), 64'd1);
        chk("t3_aw0_addr", 64'(aw_addr_q[0]), 64'h2000);
        chk("t3_pops", 64'(pops), 64'd16);
        chk("t3_gaps", 64'(gap_err), 64'd0);
        fifo_rd_cnt = 10'd512;
        step(3);

        // Backpressure: awready after 7 stall cycles, wready toggling
        clear_logs();
        aw_delay = 7;
        w_toggle = 1'b1;
        start_job(30'h4000, 16'd32);
        step(1);
        wr_addr_valid = 1'b0;
        wait_done(4, 800, "t4_done");
        chk("t4_aw_count", 64'(aw_addr_q.size()), 64'd2);
        chk("t4_aw1_addr", 64'(aw_addr_q[1]), 64'h4200);
        chk("t4_aw0_stall", 64'(aw_stall_q[0]), 64'd7);
        chk("t4_aw1_stall", 64'(aw_stall_q[1]), 64'd7);
        chk("t4_wlast0", 64'(wlast_q[0]), 64'd15);
        chk("t4_wlast1", 64'(wlast_q[1]), 64'd15);
        chk("t4_pops", 64'(pops), 64'd32);
        chk("t4_aw_stable", 64'(aw_stab_err), 64'd0);
        chk("t4_w_stable", 64'(w_stab_err), 64'd0);
        aw_delay = 0;
        w_toggle = 1'b0;
        step(3);

        // Zero length, then back-to-back job held on valid
        clear_logs();
        base = done_cnt;
        start_job(30'h8000, 16'd0);
        step(1);
        chk("t5_zero_done", 64'(wr_ddr_done), 64'd1);
        chk("t5_zero_busy", 64'(busy), 64'd1);
        wr_ddr_addr = 30'h9000;
        wr_ddr_num  = 16'd16;
        step(1);
        chk("t5_cool_done", 64'(wr_ddr_done), 64'd0);
        chk("t5_cool_busy", 64'(busy), 64'd1);
        step(1);
        chk("t5_idle_busy", 64'(busy), 64'd0);
        step(1);
        chk("t5_second_accept", 64'(busy), 64'd1);
        wr_addr_valid = 1'b0;
        wait_done(base + 2, 400, "t5_done");
        chk("t5_aw_count", 64'(aw_addr_q.size()), 64'd1);
        chk("t5_aw0_addr", 64'(aw_addr_q[0]), 64'h9000);
        chk("t5_pops", 64'(pops), 64'd16);
        step(3);

        // Reset for one cycle while beat 8 is presented
        clear_logs();
        base  = done_cnt;
        found = 1'b0;
        start_job(30'hA000, 16'd32);
        step(1);
        wr_addr_valid = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1);
            if (tb_beat == 8 && m_wvalid === 1'b1) found = 1'b1;
        end
        chk("t6_reached_beat8", 64'(found), 64'd1);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("t6_awvalid", 64'(m_awvalid), 64'd0);
        chk("t6_wvalid", 64'(m_wvalid), 64'd0);
        chk("t6_wlast", 64'(m_wlast), 64'd0);
        chk("t6_bready", 64'(m_bready), 64'd0);
        chk("t6_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_done", 64'(wr_ddr_done), 64'd0);
        step(20);
        chk("t6_no_done", 64'(done_cnt), 64'(base));
        clear_logs();
        start_job(30'hB000, 16'd16);
        step(1);
        wr_addr_valid = 1'b0;
        wait_done(base + 1, 400, "t6_new_done");
        chk("t6_aw_count", 64'(aw_addr_q.size()), 64'd1);
        chk("t6_aw0_addr", 64'(aw_addr_q[0]), 64'hB000);
        chk("t6_pops", 64'(pops), 64'd16);
        step(3);

        // Whole-run invariants
        chk("all_data", 64'(data_err), 64'd0);
        chk("all_rd_en", 64'(rden_err), 64'd0);
        chk("all_done_width", 64'(done_dbl), 64'd0);
        chk("all_gaps", 64'(gap_err), 64'd0);
        chk("all_wstrb", 64'(&m_wstrb), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
